// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB; ALU/branch/NOP 3 cycles, STOR 3, LOAD 4, +1 per memory wait.
// Holds mem_req/mem_we/addr_sel stable until mem_ack; CPU_FSM_ZEXT_LOGIC_EN makes ANDI/ORI/XORI zero-extend.
module cpu_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        mem_ack,
  input  logic        cond_true,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_en,
  output logic        pc_en,
  output logic        pc_src,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        flags_we,
  output logic        imm_sel,
  output logic        sext_s,
  output logic [3:0]  alu_op,
  output logic        retire
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [3:0] op;
  logic [3:0] ext;
  logic [3:0] alu_code;
  logic       is_rtype_alu;
  logic       is_imm_alu;
  logic       is_alu;
  logic       is_load;
  logic       is_stor;
  logic       is_branch;
  logic       alu_writes_reg;
  logic       alu_writes_flags;
  logic       zext_logic;
  logic       unused_instr_bits;

  function automatic logic alu_code_ok(input logic [3:0] c);
    case (c)
      4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD: alu_code_ok = 1'b1;
      default:                                  alu_code_ok = 1'b0;
    endcase
  endfunction

  assign op  = instr[15:12];
  assign ext = instr[7:4];

  // R-type carries the ALU code in ext; immediate forms reuse the same code as op.
  assign is_rtype_alu     = (op == 4'h0) && alu_code_ok(ext);
  assign is_imm_alu       = (op != 4'h0) && alu_code_ok(op);
  assign is_alu           = is_rtype_alu || is_imm_alu;
  assign alu_code         = is_rtype_alu ? ext : op;
  assign alu_writes_reg   = is_alu && (alu_code != 4'hB);
  assign alu_writes_flags = is_alu && ((alu_code == 4'h5) || (alu_code == 4'h9) || (alu_code == 4'hB));
  assign is_load          = (op == 4'h4) && (ext == 4'h0);
  assign is_stor          = (op == 4'h4) && (ext == 4'h4);
  assign is_branch        = (op == 4'hC);

`ifdef CPU_FSM_ZEXT_LOGIC_EN
  assign zext_logic = is_imm_alu && ((op == 4'h1) || (op == 4'h2) || (op == 4'h3));
`else
  assign zext_logic = 1'b0;
`endif

  // Register fields are routed by the datapath; the sequencer never looks at them.
  assign unused_instr_bits = ^{instr[11:8], instr[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_src   = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = 1'b0;
    flags_we = 1'b0;
    imm_sel  = 1'b0;
    alu_op   = 4'h0;
    retire   = 1'b0;
    sext_s   = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        ir_en   = mem_ack;
        if (mem_ack) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU controls are set up early so operands settle before EXEC.
        if (is_alu) begin
          alu_op  = alu_code;
          imm_sel = is_imm_alu;
        end
        if (zext_logic) begin
          sext_s = 1'b0;
        end
        state_d = (is_load || is_stor) ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        pc_en  = 1'b1;
        retire = 1'b1;
        pc_src = is_branch && cond_true;
        if (is_alu) begin
          alu_op   = alu_code;
          imm_sel  = is_imm_alu;
          reg_we   = alu_writes_reg;
          flags_we = alu_writes_flags;
        end
        if (zext_logic) begin
          sext_s = 1'b0;
        end
        state_d = S_FETCH;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_stor;
        if (mem_ack) begin
          if (is_stor) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = 1'b1;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
        sext_s  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: per-cycle expected control vectors queued at drive time, checked mid-cycle.
module tb_cpu_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        mem_ack;
  logic        cond_true;
  logic        mem_req, mem_we, addr_sel, ir_en, pc_en, pc_src;
  logic        reg_we, wb_sel, flags_we, imm_sel, sext_s, retire;
  logic [3:0]  alu_op;

  typedef struct {
    string       tag;
    logic [15:0] vec;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n_retire = 0;
  int   n_instr  = 0;

`ifdef CPU_FSM_ZEXT_LOGIC_EN
  localparam logic ANDI_SX = 1'b0;
`else
  localparam logic ANDI_SX = 1'b1;
`endif

  cpu_control_fsm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .mem_ack  (mem_ack),
    .cond_true(cond_true),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .addr_sel (addr_sel),
    .ir_en    (ir_en),
    .pc_en    (pc_en),
    .pc_src   (pc_src),
    .reg_we   (reg_we),
    .wb_sel   (wb_sel),
    .flags_we (flags_we),
    .imm_sel  (imm_sel),
    .sext_s   (sext_s),
    .alu_op   (alu_op),
    .retire   (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Vector layout: req we asel ir pc psrc rwe wb fwe imm sx alu[3:0] ret
  function automatic logic [15:0] v(input logic req, input logic we, input logic asel,
                                    input logic ir, input logic pc, input logic psrc,
                                    input logic rwe, input logic wb, input logic fwe,
                                    input logic imm, input logic sx, input logic [3:0] alu,
                                    input logic ret);
    return {req, we, asel, ir, pc, psrc, rwe, wb, fwe, imm, sx, alu, ret};
  endfunction

  logic [15:0] outs;
  assign outs = {mem_req, mem_we, addr_sel, ir_en, pc_en, pc_src, reg_we, wb_sel,
                 flags_we, imm_sel, sext_s, alu_op, retire};

  always @(negedge clk) begin
    if (retire === 1'b1) n_retire++;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, outs, e.vec);
    end
  end

  task automatic cyc(input string tag, input logic rst, input logic [15:0] ins,
                     input logic ack, input logic ct, input logic [15:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n     = rst;
    instr     = ins;
    mem_ack   = ack;
    cond_true = ct;
    x.tag = tag;
    x.vec = e;
    sb.push_back(x);
  endtask

  localparam logic [15:0] ZERO = 16'h0000;

  // FETCH with a number of wait cycles, then the ack cycle.
  task automatic fetch(input string tag, input logic [15:0] ins, input int waits);
    for (int i = 0; i < waits; i++)
      cyc({tag, "_fwait"}, 1'b1, ins, 1'b0, 1'b0, v(1,0,0,0,0,0,0,0,0,0,1,4'h0,0));
    cyc({tag, "_fetch"}, 1'b1, ins, 1'b1, 1'b0, v(1,0,0,1,0,0,0,0,0,0,1,4'h0,0));
    n_instr++;
  endtask

  initial begin
    rst_n = 1'b0; instr = 16'h0; mem_ack = 1'b1; cond_true = 1'b0;

    for (int i = 0; i < 3; i++)
      cyc("reset", 1'b0, 16'h0, 1'b1, 1'b0, ZERO);
    cyc("idle", 1'b1, 16'h0, 1'b1, 1'b0, ZERO);

    // ADDI
    fetch("addi", 16'h5305, 0);
    cyc("addi_dec",  1'b1, 16'h5305, 1'b1, 1'b0, v(0,0,0,0,0,0,0,0,0,1,1,4'h5,0));
    cyc("addi_exec", 1'b1, 16'h5305, 1'b0, 1'b0, v(0,0,0,0,1,0,1,0,1,1,1,4'h5,1));

    // LOAD with two memory wait cycles
    fetch("load", 16'h4203, 0);
    cyc("load_dec",  1'b1, 16'h4203, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,0,0,1,4'h0,0));
    cyc("load_mw0",  1'b1, 16'h4203, 1'b0, 1'b0, v(1,0,1,0,0,0,0,0,0,0,1,4'h0,0));
    cyc("load_mw1",  1'b1, 16'h4203, 1'b0, 1'b0, v(1,0,1,0,0,0,0,0,0,0,1,4'h0,0));
    cyc("load_mack", 1'b1, 16'h4203, 1'b1, 1'b0, v(1,0,1,0,0,0,0,0,0,0,1,4'h0,0));
    cyc("load_wb",   1'b1, 16'h4203, 1'b1, 1'b0, v(0,0,0,0,1,0,1,1,0,0,1,4'h0,1));

    // Branch taken, then not taken (with one fetch wait)
    fetch("brt", 16'hC0FE, 0);
    cyc("brt_dec",  1'b1, 16'hC0FE, 1'b0, 1'b1, v(0,0,0,0,0,0,0,0,0,0,1,4'h0,0));
    cyc("brt_exec", 1'b1, 16'hC0FE, 1'b0, 1'b1, v(0,0,0,0,1,1,0,0,0,0,1,4'h0,1));
    fetch("brn", 16'hC0FE, 1);
    cyc("brn_dec",  1'b1, 16'hC0FE, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,0,0,1,4'h0,0));
    cyc("brn_exec", 1'b1, 16'hC0FE, 1'b0, 1'b0, v(0,0,0,0,1,0,0,0,0,0,1,4'h0,1));

    // ANDI: extension mode depends on build option
    fetch("andi", 16'h1FFF, 0);
    cyc("andi_dec",  1'b1, 16'h1FFF, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,0,1,ANDI_SX,4'h1,0));
    cyc("andi_exec", 1'b1, 16'h1FFF, 1'b0, 1'b0, v(0,0,0,0,1,0,1,0,0,1,ANDI_SX,4'h1,1));

    // CMP (R-type, ext=1011): flags only
    fetch("cmp", 16'h01B2, 0);
    cyc("cmp_dec",  1'b1, 16'h01B2, 1'b1, 1'b0, v(0,0,0,0,0,0,0,0,0,0,1,4'hB,0));
    cyc("cmp_exec", 1'b1, 16'h01B2, 1'b1, 1'b0, v(0,0,0,0,1,0,0,0,1,0,1,4'hB,1));

    // 16'h0B12 has ext=0001: register AND, no flags
    fetch("and", 16'h0B12, 0);
    cyc("and_dec",  1'b1, 16'h0B12, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,0,0,1,4'h1,0));
    cyc("and_exec", 1'b1, 16'h0B12, 1'b0, 1'b0, v(0,0,0,0,1,0,1,0,0,0,1,4'h1,1));

    // MOV register form
    fetch("mov", 16'h01D2, 0);
    cyc("mov_dec",  1'b1, 16'h01D2, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,0,0,1,4'hD,0));
    cyc("mov_exec", 1'b1, 16'h01D2, 1'b0, 1'b0, v(0,0,0,0,1,0,1,0,0,0,1,4'hD,1));

    // Unknown encoding behaves as NOP
    fetch("nop", 16'hF000, 2);
    cyc("nop_dec",  1'b1, 16'hF000, 1'b1, 1'b1, v(0,0,0,0,0,0,0,0,0,0,1,4'h0,0));
    cyc("nop_exec", 1'b1, 16'hF000, 1'b1, 1'b1, v(0,0,0,0,1,0,0,0,0,0,1,4'h0,1));

    // STOR abandoned by reset during MEM (ack present in the reset cycle)
    fetch("stor_rst", 16'h4143, 0);
    n_instr--;
    cyc("storr_dec",  1'b1, 16'h4143, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,0,0,1,4'h0,0));
    cyc("storr_mem",  1'b1, 16'h4143, 1'b0, 1'b0, v(1,1,1,0,0,0,0,0,0,0,1,4'h0,0));
    cyc("storr_rst0", 1'b0, 16'h4143, 1'b1, 1'b0, ZERO);
    cyc("storr_rst1", 1'b0, 16'h4143, 1'b1, 1'b0, ZERO);
    cyc("storr_idle", 1'b1, 16'h4143, 1'b1, 1'b0, ZERO);

    // Refetch and complete the STOR
    fetch("stor", 16'h4143, 0);
    cyc("stor_dec", 1'b1, 16'h4143, 1'b1, 1'b0, v(0,0,0,0,0,0,0,0,0,0,1,4'h0,0));
    cyc("stor_mem", 1'b1, 16'h4143, 1'b1, 1'b0, v(1,1,1,0,1,0,0,0,0,0,1,4'h0,1));
    cyc("next_fetch", 1'b1, 16'h0000, 1'b0, 1'b0, v(1,0,0,0,0,0,0,0,0,0,1,4'h0,0));

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", 16'(sb.size()), 16'd0);
    chk("retire_count", 16'(n_retire), 16'(n_instr));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
